// File: rtl/noc_output_lock.sv
// noc_output_lock
// Output-port controller for one router output. It sits directly behind the
// round-robin arbiter for that output. Its jobs are:
//   - gate the input request vector into the arbiter (no requests without credit
//     or while a packet holds the port);
//   - accept the one-hot grant and move the granted head flit in the same cycle;
//   - hold the granted input (wormhole lock) until that packet's tail flit passes;
//   - keep a credit count toward the downstream buffer and flag excess credits.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   i_valid       in   [0:N-1] per-input flit valid (head of each input FIFO)
//   i_tail        in   [0:N-1] per-input tail marker for the current flit
//   i_data        in   N*FLIT_W packed flit data; input k at [k*FLIT_W +: FLIT_W]
//   o_ack         out  [0:N-1] one-hot pop to the input FIFO whose flit moved
//   o_request     out  [0:N-1] gated request vector to the arbiter
//   i_grant       in   [0:N-1] one-hot combinational grant from the arbiter
//   o_ce          out  arbiter clock enable; pulses when a head flit is accepted
//   o_valid       out  output flit valid
//   o_data        out  output flit data (0 when o_valid=0)
//   o_tail        out  output flit is a tail (0 when o_valid=0)
//   i_credit      in   downstream released one buffer slot
//   o_credit_err  out  sticky: a credit arrived while the count was already full
module noc_output_lock #(
    parameter int N      = 5,
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [0:N-1]        i_valid,
    input  logic [0:N-1]        i_tail,
    input  logic [N*FLIT_W-1:0] i_data,
    output logic [0:N-1]        o_ack,
    output logic [0:N-1]        o_request,
    input  logic [0:N-1]        i_grant,
    output logic                o_ce,
    output logic                o_valid,
    output logic [FLIT_W-1:0]   o_data,
    output logic                o_tail,
    input  logic                i_credit,
    output logic                o_credit_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    logic          state_q, state_d;
    logic [0:N-1]  sel_q, sel_d;
    logic [CW-1:0] cred_q, cred_d;
    logic          err_q, err_d;

    // Only the registered count enables a send; a credit arriving this cycle
    // is usable from the next cycle on.
    logic can_send;
    assign can_send = (cred_q != '0);

    logic [0:N-1] req_idle;
    logic         grant_ok;
    assign req_idle = can_send ? i_valid : '0;
    // A usable grant is exactly one bit and only for an input we asked for;
    // anything else moves nothing.
    assign grant_ok = $onehot(i_grant) && ((i_grant & ~req_idle) == '0);

    // Which input drives the output this cycle, and whether a flit moves.
    logic [0:N-1] sel_vec;
    logic         xfer;

    always_comb begin
        o_request = '0;
        o_ce      = 1'b0;
        xfer      = 1'b0;
        sel_vec   = '0;
        // Everything is forced quiet while reset is held, including mid-packet.
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    o_request = req_idle;
                    if (grant_ok) begin
                        xfer    = 1'b1;
                        sel_vec = i_grant;
                        o_ce    = 1'b1;
                    end
                end
                default: begin
                    sel_vec = sel_q;
                    xfer    = (|(i_valid & sel_q)) && can_send;
                end
            endcase
        end
    end

    // One-hot AND-OR data mux.
    logic [FLIT_W-1:0] masked [N];
    logic [FLIT_W-1:0] mux_data;

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign masked[gi] = sel_vec[gi] ? i_data[gi*FLIT_W +: FLIT_W] : '0;
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            mux_data = mux_data | masked[k];
        end
    end

    logic tail_sel;
    assign tail_sel = |(sel_vec & i_tail);

    assign o_valid      = xfer;
    assign o_ack        = xfer ? sel_vec : '0;
    assign o_data       = xfer ? mux_data : '0;
    assign o_tail       = xfer & tail_sel;
    assign o_credit_err = err_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cred_d  = cred_q;
        err_d   = err_q;

        if (xfer) begin
            if (state_q == ST_IDLE && !tail_sel) begin
                state_d = ST_LOCKED;
                sel_d   = i_grant;
            end else if (state_q == ST_LOCKED && tail_sel) begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        end

        // Send and credit together cancel out; an extra credit on a full
        // count is dropped and latched as an error.
        case ({xfer, i_credit})
            2'b10: cred_d = cred_q - 1'b1;
            2'b01: begin
                if (cred_q == CRED_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cred_d = cred_q + 1'b1;
                end
            end
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cred_q  <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    // The arbiter must only hand out one-hot grants drawn from our requests.
    assert property (@(posedge clk) disable iff (reset)
        ((state_q == ST_IDLE) && (|i_grant)) |-> grant_ok);

endmodule

// File: tb/tb_noc_output_lock.sv
// Directed bench for noc_output_lock (N=5, FLIT_W=32, DEPTH=4). The bench plays
// the arbiter by driving i_grant directly. Input k carries data 32'hD000_000k.
module tb_noc_output_lock;

    localparam int N = 5;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [0:N-1]   i_valid, i_tail, i_grant;
    logic [N*W-1:0] i_data;
    logic [0:N-1]   o_ack, o_request;
    logic           o_ce, o_valid, o_tail, i_credit, o_credit_err;
    logic [W-1:0]   o_data;

    int checks   = 0;
    int failures = 0;

    noc_output_lock #(.N(N), .FLIT_W(W), .DEPTH(4)) u_dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_tail(i_tail), .i_data(i_data),
        .o_ack(o_ack), .o_request(o_request), .i_grant(i_grant),
        .o_ce(o_ce), .o_valid(o_valid), .o_data(o_data), .o_tail(o_tail),
        .i_credit(i_credit), .o_credit_err(o_credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [0:N-1] v, input logic [0:N-1] t,
                         input logic [0:N-1] g, input logic c);
        i_valid  = v;
        i_tail   = t;
        i_grant  = g;
        i_credit = c;
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int k = 0; k < N; k++) i_data[k*W +: W] = 32'hD000_0000 + k;
        reset = 1'b1;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        #2;
        // During reset a valid grant must move nothing.
        drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_req", o_request, 5'b00000);
        chk("rst_ack", o_ack, 5'b00000);
        chk("rst_err", o_credit_err, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick();

        // Single-flit packet on input 2, same-cycle transfer, stays idle. cred 4->3
        drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
        #1;
        chk("t1_req", o_request, 5'b00100);
        chk("t1_valid", o_valid, 1'b1);
        chk("t1_ack", o_ack, 5'b00100);
        chk("t1_ce", o_ce, 1'b1);
        chk("t1_data", o_data, 32'hD000_0002);
        chk("t1_tail", o_tail, 1'b1);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("t1_idle_valid", o_valid, 1'b0);
        chk("t1_idle_data", o_data, 32'h0);
        chk("t1_idle_tail", o_tail, 1'b0);
        tick();

        // 3-flit packet on input 1 while input 3 also waits. Credits returned
        // alongside flits 2 and 3 keep the count at 2.
        drive(5'b01010, 5'b00000, 5'b01000, 1'b0);
        #1;
        chk("t2_req_head", o_request, 5'b01010);
        chk("t2_ack_head", o_ack, 5'b01000);
        chk("t2_ce_head", o_ce, 1'b1);
        chk("t2_data_head", o_data, 32'hD000_0001);
        chk("t2_tail_head", o_tail, 1'b0);
        tick();
        drive(5'b01010, 5'b00000, 5'b00010, 1'b1);  // stray grant must be ignored
        #1;
        chk("t2_req_body", o_request, 5'b00000);
        chk("t2_ce_body", o_ce, 1'b0);
        chk("t2_ack_body", o_ack, 5'b01000);
        chk("t2_data_body", o_data, 32'hD000_0001);
        tick();
        drive(5'b01010, 5'b01000, 5'b00000, 1'b1);
        #1;
        chk("t2_ack_tail", o_ack, 5'b01000);
        chk("t2_tail_tail", o_tail, 1'b1);
        tick();
        drive(5'b00010, 5'b00010, 5'b00010, 1'b0);
        #1;
        chk("t2_req_next", o_request, 5'b00010);
        chk("t2_ack_next", o_ack, 5'b00010);
        chk("t2_ce_next", o_ce, 1'b1);
        chk("t2_data_next", o_data, 32'hD000_0003);
        tick();  // cred 1

        // Packet on input 0 uses the last credit, then stalls.
        drive(5'b10000, 5'b00000, 5'b10000, 1'b0);
        #1;
        chk("t3_ack_head", o_ack, 5'b10000);
        tick();  // cred 0, locked
        drive(5'b10000, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("t3_stall_valid", o_valid, 1'b0);
        chk("t3_stall_ack", o_ack, 5'b00000);
        chk("t3_stall_req", o_request, 5'b00000);
        tick();
        // Credit arriving now does not enable a send in the same cycle.
        drive(5'b10000, 5'b00000, 5'b00000, 1'b1);
        #1;
        chk("t4_same_cycle_valid", o_valid, 1'b0);
        chk("t4_same_cycle_ack", o_ack, 5'b00000);
        tick();  // cred 1
        drive(5'b10000, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("t4_next_valid", o_valid, 1'b1);
        chk("t4_next_ack", o_ack, 5'b10000);
        chk("t4_next_data", o_data, 32'hD000_0000);
        tick();  // cred 0 again
        #1;
        chk("t4_back_to_zero", o_valid, 1'b0);

        // Reset mid-packet: outputs drop at once.
        reset = 1'b1;
        drive(5'b10000, 5'b00000, 5'b10000, 1'b0);
        #1;
        chk("t6_rst_valid", o_valid, 1'b0);
        chk("t6_rst_ack", o_ack, 5'b00000);
        chk("t6_rst_req", o_request, 5'b00000);
        chk("t6_rst_ce", o_ce, 1'b0);
        chk("t6_rst_data", o_data, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick();
        // Four single-flit grants accepted (idle state, full count of 4).
        for (int i = 0; i < 4; i++) begin
            drive(5'b10000, 5'b10000, 5'b10000, 1'b0);
            #1;
            chk($sformatf("t6_grant%0d_ack", i), o_ack, 5'b10000);
            chk($sformatf("t6_grant%0d_ce", i), o_ce, 1'b1);
            tick();
        end
        drive(5'b10000, 5'b10000, 5'b00000, 1'b0);
        #1;
        chk("t6_empty_req", o_request, 5'b00000);
        tick();

        // Refill to 4 without error, then one excess credit.
        for (int i = 0; i < 4; i++) begin
            drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
            tick();
        end
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("t5_full_no_err", o_credit_err, 1'b0);
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
        tick();
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("t5_err_set", o_credit_err, 1'b1);
        tick();
        // Count held at 4: exactly four sends, then requests are blocked.
        for (int i = 0; i < 4; i++) begin
            drive(5'b00100, 5'b00100, 5'b00100, 1'b0);
            #1;
            chk($sformatf("t5_send%0d_ack", i), o_ack, 5'b00100);
            tick();
        end
        drive(5'b00100, 5'b00100, 5'b00000, 1'b0);
        #1;
        chk("t5_held_at_depth", o_request, 5'b00000);
        chk("t5_err_sticky", o_credit_err, 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_err_cleared", o_credit_err, 1'b0);
        tick();
        reset = 1'b0;
        drive(5'b00000, 5'b00000, 5'b00000, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
